// File: rtl/cplx_pkg.sv
// Shared definitions for the complex dot-product sequencer: default widths,
// controller state encoding and a packed complex-sample type.
package cplx_pkg;

    localparam int CPLX_DW      = 32;
    localparam int CPLX_AW      = 72;
    localparam int CPLX_LEN_W   = 8;
    localparam int CPLX_MUL_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [CPLX_DW-1:0] re;
        logic signed [CPLX_DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/cplx_mul_pipe.sv
// Pipelined full-precision complex multiplier. The four partial products and
// the re/im combination are formed ahead of the first register, and the result
// then travels through MUL_LAT register stages. A valid bit travels with the
// data; only the valid bits are reset, the data registers are don't-care when
// their valid bit is low.
module cplx_mul_pipe
    import cplx_pkg::*;
#(
    parameter int DW      = CPLX_DW,
    parameter int MUL_LAT = CPLX_MUL_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_v,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic                 out_v,
    output logic                 pend,
    output logic signed [2*DW:0] p_re,
    output logic signed [2*DW:0] p_im
);

    localparam int PW = 2*DW + 1;

    // Operands sign-extended to 2*DW bits so the low 2*DW bits of the
    // unsigned product equal the exact signed product.
    logic [2*DW-1:0] ar_x, ai_x, br_x, bi_x;
    logic [2*DW-1:0] rr, ii, ri, ir;
    logic [PW-1:0]   re_c, im_c;

    logic [MUL_LAT-1:0] v_q;
    logic [PW-1:0]      re_q [MUL_LAT];
    logic [PW-1:0]      im_q [MUL_LAT];

    // Partial products and their one-bit-wider sum/difference.
    always_comb begin
        ar_x = {{DW{a_re[DW-1]}}, a_re};
        ai_x = {{DW{a_im[DW-1]}}, a_im};
        br_x = {{DW{b_re[DW-1]}}, b_re};
        bi_x = {{DW{b_im[DW-1]}}, b_im};
        rr   = ar_x * br_x;
        ii   = ai_x * bi_x;
        ri   = ar_x * bi_x;
        ir   = ai_x * br_x;
        re_c = {rr[2*DW-1], rr} - {ii[2*DW-1], ii};
        im_c = {ri[2*DW-1], ri} + {ir[2*DW-1], ir};
    end

    // Valid bits advance every cycle so bubbles are tracked exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
        end else begin
            v_q[0] <= in_v;
            for (int i = 1; i < MUL_LAT; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    // Data stages follow the valid bits without reset.
    always_ff @(posedge clk) begin
        re_q[0] <= re_c;
        im_q[0] <= im_c;
        for (int i = 1; i < MUL_LAT; i++) begin
            re_q[i] <= re_q[i-1];
            im_q[i] <= im_q[i-1];
        end
    end

    assign out_v = v_q[MUL_LAT-1];
    assign p_re  = re_q[MUL_LAT-1];
    assign p_im  = im_q[MUL_LAT-1];

    // pend: a product is still travelling behind the output stage.
    if (MUL_LAT > 1) begin : g_pend
        assign pend = |v_q[MUL_LAT-2:0];
    end else begin : g_nopend
        assign pend = 1'b0;
    end

endmodule

// File: rtl/cplx_dot_ctrl.sv
// Complex dot-product sequencer: accepts a start command with a length,
// streams len operand pairs through one shared pipelined complex multiplier,
// drains the pipeline and presents the accumulated sum.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state (high in FEED); out_valid depends
// only on state (high in DONE) and out_re/out_im are stable while it is high.
module cplx_dot_ctrl
    import cplx_pkg::*;
#(
    parameter int DW      = CPLX_DW,
    parameter int AW      = CPLX_AW,
    parameter int LEN_W   = CPLX_LEN_W,
    parameter int MUL_LAT = CPLX_MUL_LAT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_re,
    output logic signed [AW-1:0] out_im,
    output logic [1:0]           dbg_state
);

    localparam int PW = 2*DW + 1;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_FEED  = ST_FEED;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]           state, state_n;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt;
    logic signed [AW-1:0] acc_re, acc_im;
    logic                 accept;
    logic                 mo_v, mo_pend;
    logic signed [PW-1:0] p_re, p_im;

    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_FEED);
    assign out_valid = (state == S_DONE);
    assign accept    = in_ready & in_valid;
    assign out_re    = acc_re;
    assign out_im    = acc_im;
    assign dbg_state = state;

    cplx_mul_pipe #(
        .DW      (DW),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .in_v  (accept),
        .a_re  (a_re),
        .a_im  (a_im),
        .b_re  (b_re),
        .b_im  (b_im),
        .out_v (mo_v),
        .pend  (mo_pend),
        .p_re  (p_re),
        .p_im  (p_im)
    );

    // Next-state logic; DRAIN ends when the last product is at the output
    // with nothing behind it, i.e. on the edge that adds it.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = (len == '0) ? S_DONE : S_FEED;
            S_FEED:  if (accept && (cnt == len_q - LEN_W'(1))) state_n = S_DRAIN;
            S_DRAIN: if (mo_v && !mo_pend) state_n = S_DONE;
            S_DONE:  if (out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Length capture on start and count of accepted samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q <= '0;
            cnt   <= '0;
        end else if (state == S_IDLE && start) begin
            len_q <= len;
            cnt   <= '0;
        end else if (accept) begin
            cnt <= cnt + LEN_W'(1);
        end
    end

    // Modulo-2^AW accumulation of sign-extended products; cleared on start,
    // otherwise held so the result stays visible in DONE and IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (state == S_IDLE && start) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (mo_v) begin
            acc_re <= acc_re + {{(AW-PW){p_re[PW-1]}}, p_re};
            acc_im <= acc_im + {{(AW-PW){p_im[PW-1]}}, p_im};
        end
    end

endmodule

// File: tb/tb_cplx_dot_ctrl.sv
// Directed self-checking bench for cplx_dot_ctrl: basic sum, backpressure,
// zero length, extreme operands, reset mid-FEED and a few randomised runs
// against a wide-integer reference sum.
module tb_cplx_dot_ctrl;
    import cplx_pkg::*;

    localparam int DW      = 32;
    localparam int AW      = 72;
    localparam int LEN_W   = 8;
    localparam int MUL_LAT = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [LEN_W-1:0]     len = '0;
    logic                 busy;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [AW-1:0] out_re, out_im;
    logic [1:0]           dbg_state;

    cplx_t sa [256];
    cplx_t sb [256];

    int n_cmp = 0;
    int n_err = 0;

    cplx_dot_ctrl #(
        .DW(DW), .AW(AW), .LEN_W(LEN_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im), .dbg_state(dbg_state)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input int n, input cplx_t a, input cplx_t b);
        for (int k = 0; k < n; k++) begin
            sa[k] = a;
            sb[k] = b;
        end
    endtask

    // One full transaction: start, feed n samples with the chosen stall
    // pattern (0 gapless, 1 alternate, 2 random), wait for DONE, hold
    // out_ready low for 'hold' cycles, then handshake back to IDLE.
    task automatic run(input string tag, input int n, input int stall, input int hold,
                       input logic signed [AW-1:0] exp_re, input logic signed [AW-1:0] exp_im);
        int   e, k, last_acc, guard;
        logic fire;
        start = 1'b1;
        len   = n[LEN_W-1:0];
        tick();
        start = 1'b0;
        len   = 8'hA5;
        e = 0; k = 0; last_acc = 0; guard = 0;
        if (n > 0) check({tag, " in_ready_feed"}, in_ready, 1'b1);
        while (k < n && guard < 4000) begin
            case (stall)
                0:       in_valid = 1'b1;
                1:       in_valid = (guard % 2 == 0);
                default: in_valid = ($urandom_range(0, 3) != 0);
            endcase
            a_re = sa[k].re; a_im = sa[k].im;
            b_re = sb[k].re; b_im = sb[k].im;
            fire = in_valid && in_ready;
            tick();
            e++;
            guard++;
            if (fire) begin
                k++;
                last_acc = e;
            end
        end
        in_valid = 1'b0;
        if (k < n) check({tag, " feed_timeout"}, k, n);
        guard = 0;
        while (!out_valid && guard < 100) begin
            tick();
            e++;
            guard++;
        end
        check({tag, " out_valid"}, out_valid, 1'b1);
        if (n > 0) check({tag, " latency"}, e - last_acc, MUL_LAT);
        // Gapless: DONE on edge len+MUL_LAT; len=0 goes to DONE on the start edge.
        if (stall == 0) check({tag, " done_edge"}, e, (n > 0) ? n + MUL_LAT : 0);
        check({tag, " out_re"}, out_re, exp_re);
        check({tag, " out_im"}, out_im, exp_im);
        check({tag, " in_ready_done"}, in_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = (h == 1);
            len       = 8'd3;
            tick();
            start = 1'b0;
            check({tag, " hold_valid"}, out_valid, 1'b1);
            check({tag, " hold_re"}, out_re, exp_re);
            check({tag, " hold_im"}, out_im, exp_im);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " idle_valid"}, out_valid, 1'b0);
        check({tag, " idle_state"}, dbg_state, ST_IDLE);
        check({tag, " idle_busy"}, busy, 1'b0);
        check({tag, " idle_keep_re"}, out_re, exp_re);
    endtask

    initial begin
        logic signed [AW-1:0] er, ei, ar, ai, br, bi, ext_im;
        int n;

        // Reset state.
        tick();
        tick();
        check("rst busy", busy, 1'b0);
        check("rst in_ready", in_ready, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_re", out_re, '0);
        check("rst out_im", out_im, '0);
        check("rst state", dbg_state, ST_IDLE);
        reset = 1'b0;
        tick();

        // Basic sum: 4 x (1+2j)(3+4j) = 4 x (-5+10j).
        fill_const(4, '{re: 32'sd1, im: 32'sd2}, '{re: 32'sd3, im: 32'sd4});
        run("basic", 4, 0, 0, -72'sd20, 72'sd40);

        // Backpressure: alternate input stalls, 5 cycles of out_ready low.
        run("bp", 4, 1, 5, -72'sd20, 72'sd40);

        // Zero length.
        run("zero", 0, 0, 0, 72'sd0, 72'sd0);

        // Extremes: (-2^31)(1+j) squared = 2^63 j per sample.
        fill_const(255, '{re: 32'sh80000000, im: 32'sh80000000},
                        '{re: 32'sh80000000, im: 32'sh80000000});
        ext_im = 72'd255;
        ext_im = ext_im <<< 63;
        run("extreme", 255, 0, 0, 72'sd0, ext_im);

        // Reset after 2 of 4 samples.
        fill_const(4, '{re: 32'sd1, im: 32'sd2}, '{re: 32'sd3, im: 32'sd4});
        start = 1'b1;
        len   = 8'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        a_re = 32'sd1; a_im = 32'sd2; b_re = 32'sd3; b_im = 32'sd4;
        tick();
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst busy", busy, 1'b0);
        check("midrst in_ready", in_ready, 1'b0);
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst out_re", out_re, '0);
        check("midrst out_im", out_im, '0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("midrst quiet_re", out_re, '0);
        check("midrst quiet_state", dbg_state, ST_IDLE);
        // (5-3j)(2+7j) = 10+21 + (35-6)j = 31+29j.
        fill_const(1, '{re: 32'sd5, im: -32'sd3}, '{re: 32'sd2, im: 32'sd7});
        run("after_rst", 1, 0, 0, 72'sd31, 72'sd29);

        // Randomised runs against a wide-integer reference sum.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 255);
            er = '0;
            ei = '0;
            for (int k = 0; k < n; k++) begin
                sa[k] = {$urandom(), $urandom()};
                sb[k] = {$urandom(), $urandom()};
                ar = sa[k].re; ai = sa[k].im;
                br = sb[k].re; bi = sb[k].im;
                er = er + ar * br - ai * bi;
                ei = ei + ar * bi + ai * br;
            end
            run($sformatf("rand%0d", r), n, 2, $urandom_range(0, 3), er, ei);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
